// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Initiator side of the program-memory read path. This block owns the program
// counter and drives it straight out as the ROM address. It registers the
// instruction that the combinational ROM returns. It then hands that
// instruction to decode over a valid/ready handshake. A redirect input
// performs jumps and flushes. With WRAP=0 the unit halts once END_ADDR has
// been delivered.
//
// Handshake: ins_out/ins_pc are meaningful only while ins_valid=1. A transfer
// happens on a rising edge where ins_valid=1 and ins_ready=1. While ins_valid=1
// and ins_ready=0, ins_out, ins_pc and ins_valid are held unchanged. The
// register slot may take a new instruction when it is empty (!ins_valid) or
// is being emptied this cycle (ins_ready).
//
// Ports
//   clk             in   1       system clock, rising edge
//   rst             in   1       synchronous reset, active-high
//   en              in   1       run enable (0 = no new fetches)
//   pm_addr         out  ADDR_W  program-memory address (the PC register)
//   pm_data         in   INS_W   instruction from program memory, same cycle
//   ins_out         out  INS_W   fetched instruction
//   ins_pc          out  ADDR_W  address ins_out was fetched from
//   ins_valid       out  1       ins_out/ins_pc valid
//   ins_ready       in   1       decode accepts ins_out this cycle
//   redirect_valid  in   1       load PC with redirect_addr, flush output
//   redirect_addr   in   ADDR_W  redirect target
//   halted          out  1       program finished (HALT state)
//   fsm_state       out  2       debug view of the FSM: 0=RUN 1=DRAIN 2=HALT
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W   = 5,
    parameter int INS_W    = 6,
    parameter int END_ADDR = 16,
    parameter int WRAP     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [INS_W-1:0]  pm_data,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(END_ADDR);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              slot_free;
    logic              xfer;

    assign slot_free = !ins_valid || ins_ready;
    assign xfer      = ins_valid && ins_ready;
    assign pm_addr   = pc;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            pc        <= '0;
            ins_out   <= '0;
            ins_pc    <= '0;
            ins_valid <= 1'b0;
            halted    <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect beats fetch, stall and halt: any pending instruction is
            // discarded, even if decode is accepting it this cycle.
            state     <= S_RUN;
            pc        <= redirect_addr;
            ins_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (slot_free) begin
                        if (en) begin
                            ins_out   <= pm_data;
                            ins_pc    <= pc;
                            ins_valid <= 1'b1;
                            if (pc != END_PC) begin
                                // Targets beyond END_ADDR climb and wrap through 0.
                                pc <= pc + PC_ONE;
                            end else if (WRAP != 0) begin
                                pc <= '0;
                            end else begin
                                // Last word captured; PC parks on END_ADDR.
                                state <= S_DRAIN;
                            end
                        end else if (xfer) begin
                            ins_valid <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (slot_free) begin
                        ins_valid <= 1'b0;
                        halted    <= 1'b1;
                        state     <= S_HALT;
                    end
                end
                S_HALT: begin
                    ins_valid <= 1'b0;
                    halted    <= 1'b1;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule
